// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for serial_adder_ctrl: operand side (in_*) and result side (out_*).
// The op field exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 4 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         op;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  // Environment view: produces operands, consumes results.
  modport master (
    output in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    output op,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Adder view: consumes operands, produces results.
  modport slave (
    input  in_valid, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  op,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice, LS nibble first, carry registered between cycles.
// Optional subtraction mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus,
  output logic [1:0]           state_dbg
);
  localparam int W  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  logic            op_q;
`endif

  logic [W-1:0]    a_sh, b_sh;
  logic [3:0]      a_nib, b_nib, slice_s;
  logic            slice_c, c;
  logic            last;

  assign last = (idx_q == IW'(WORDS - 1));

  // 4-bit ripple-carry slice fed by the nibble selected by idx.
  always_comb begin
    a_sh  = a_q >> {idx_q, 2'b00};
    b_sh  = b_q >> {idx_q, 2'b00};
    a_nib = a_sh[3:0];
`ifdef SERIAL_ADDER_SUB_EN
    b_nib = b_sh[3:0] ^ {4{op_q}};
`else
    b_nib = b_sh[3:0];
`endif
    slice_s = 4'd0;
    c       = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_s[i] = a_nib[i] ^ b_nib[i] ^ c;
      c          = (a_nib[i] & b_nib[i]) | (c & (a_nib[i] ^ b_nib[i]));
    end
    slice_c = c;
  end

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; a result stays stable on sum/cout while out_valid waits for out_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx_q <= '0;
            sum_q <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            op_q    <= bus.op;
            carry_q <= bus.op ? 1'b1 : bus.cin;
`else
            carry_q <= bus.cin;
`endif
          end
        end
        RUN: begin
          // sum was cleared on accept, so OR-ing the shifted nibble writes it in place.
          sum_q   <= sum_q | (W'(slice_s) << {idx_q, 2'b00});
          carry_q <= slice_c;
          if (last) cout_q <= slice_c;
          else      idx_q  <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WORDS=4 main instance, WORDS=1 corner instance).
// Exercises subtraction as well when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WORDS(WORDS)) bus ();
  serial_adder_ctrl_if #(.WORDS(1))     bus1 ();
  logic [1:0] st, st1;

  serial_adder_ctrl #(.WORDS(WORDS)) dut  (.clk(clk), .rst(rst), .bus(bus),  .state_dbg(st));
  serial_adder_ctrl #(.WORDS(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         rdy_mode = 0;
  logic       prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic; bit W is the carry / no-borrow flag.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic op);
    logic [W:0] r;
    if (op) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    end
    return r;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency on every rising out_valid, data on every result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
        else                   chk("latency", 32'(cyc - acc_q.pop_front()), 32'(WORDS));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else                   chk("result", 32'({bus.cout, bus.sum}), 32'(exp_q.pop_front()));
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic op, output int acc);
    int t;
    bus.a = a;
    bus.b = b;
    bus.cin = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus.op = op;
`endif
    bus.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      acc = -1;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(model(a, b, c, op));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc0, acc1;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    bus.op = 1'b0;
    bus1.op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    @(posedge clk);
    #1;

    send(16'h1234, 16'h4321, 1'b0, 1'b0, acc0); bus.in_valid = 1'b0; drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc0); bus.in_valid = 1'b0; drain();

    // Backpressure: result must hold while out_ready is low and new operands are refused.
    rdy_mode = 1;
    send(16'h00FF, 16'h0000, 1'b1, 1'b0, acc0);
    bus.in_valid = 1'b0;
    repeat (WORDS) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sum", 32'(bus.sum), 32'h0100);
      chk("hold_cout", 32'(bus.cout), 32'd0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset during the second RUN cycle discards the operation.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, acc0); bus.in_valid = 1'b0; drain();

    // Back-to-back with in_valid held: WORDS+2 cycles between acceptances.
    send(W'($urandom), W'($urandom), 1'b0, 1'b0, acc0);
    send(W'($urandom), W'($urandom), 1'b1, 1'b0, acc1);
    bus.in_valid = 1'b0;
    chk("throughput_gap", 32'(acc1 - acc0), 32'(WORDS + 2));
    drain();

    // WORDS=1 instance: single RUN cycle.
    bus1.a = 4'hF; bus1.b = 4'h1; bus1.cin = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("w1_early_valid", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    chk("w1_out_valid", 32'(bus1.out_valid), 32'd1);
    chk("w1_sum", 32'(bus1.sum), 32'h0);
    chk("w1_cout", 32'(bus1.cout), 32'd1);
    @(posedge clk);
    #1;

`ifdef SERIAL_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, acc0); bus.in_valid = 1'b0; drain();
    send(16'h0007, 16'h0005, 1'b1, 1'b1, acc0); bus.in_valid = 1'b0; drain();
`endif

    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic op;
`ifdef SERIAL_ADDER_SUB_EN
      op = 1'($urandom_range(0, 1));
`else
      op = 1'b0;
`endif
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), op, acc0);
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
